// File: rtl/minimips_ctrl_pkg.sv
// rtl/minimips_ctrl_pkg.sv - shared encodings for the MiniMIPS main control unit
//
// Purpose: opcode constants, ALUop codes, datapath mux selects and the 4-bit
// state encodings. The ALU control stage and the testbench use the same package.
package minimips_ctrl_pkg;

    // Instruction opcodes (4-bit IR opcode field)
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_J     = 4'b1000;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // ALUop codes consumed by the ALU control stage
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_FUNC = 3'b111;

    // ALU operand A select
    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller state encodings
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_e;

    // True for every opcode that has an instruction assigned to it
    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_J, OP_HALT: is_legal_op = 1'b1;
            default:       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// rtl/ctrl_output_decode.sv - combinational decode of controller state to datapath strobes
//
// Purpose: Moore decode of the state register, plus the three combinationally
// qualified strobes: FETCH pc_write/ir_write (by mem_ready) and the branch
// PC load (by opcode and zero).
// Ports:
//   state_i       current controller state
//   opcode_i      IR opcode field
//   zero_i        ALU zero flag
//   mem_ready_i   memory handshake
//   *_o           datapath controls, see main_control_fsm
module ctrl_output_decode
    import minimips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic [2:0] aluop_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       illegal_o,
    output logic       halted_o
);

    logic branch_taken;

    assign branch_taken = ((opcode_i == OP_BEQ) &&  zero_i) ||
                          ((opcode_i == OP_BNE) && !zero_i);

    always_comb begin
        aluop_o         = ALU_ADD;
        alu_src_a_o     = SRCA_PC;
        alu_src_b_o     = SRCB_REG;
        pc_src_o        = PCSRC_ALU;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        illegal_o       = 1'b0;
        halted_o        = 1'b0;

        case (state_i)
            ST_FETCH: begin
                // PC+1 computed every cycle, but PC and IR only load on the
                // cycle the instruction word actually arrives.
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_ONE;
                if (mem_ready_i) begin
                    pc_write_o = 1'b1;
                    ir_write_o = 1'b1;
                end
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b_o = SRCB_IMM;
                illegal_o   = !is_legal_op(opcode_i);
            end
            ST_EXEC_R: begin
                alu_src_a_o = SRCA_REG;
                aluop_o     = ALU_FUNC;
            end
            ST_EXEC_I: begin
                alu_src_a_o = SRCA_REG;
                alu_src_b_o = SRCB_IMM;
                case (opcode_i)
                    OP_ANDI: aluop_o = ALU_AND;
                    OP_ORI:  aluop_o = ALU_OR;
                    default: aluop_o = ALU_ADD;
                endcase
            end
            ST_WB_ALU: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (opcode_i == OP_RTYPE);
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = SRCA_REG;
                alu_src_b_o = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = SRCA_REG;
                aluop_o         = ALU_SUB;
                pc_src_o        = PCSRC_ALUOUT;
                pc_write_cond_o = branch_taken;
            end
            ST_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PCSRC_JUMP;
            end
            ST_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - MiniMIPS multi-cycle main control unit
//
// Purpose: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states,
// waits on mem_ready in memory states and parks in HALT on the halt opcode.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode            IR opcode field (valid from DECODE on)
//   zero              ALU zero flag, used in BRANCH
//   mem_ready         memory completes the current access this cycle
//   ALUop             ALU operation code for the ALU control stage
//   alu_src_a/b       ALU operand selects
//   pc_src            PC source select
//   pc_write(_cond)   unconditional / branch-qualified PC load
//   iord              memory address select (0 PC, 1 ALUOut)
//   mem_read/write    memory strobes
//   ir_write          instruction register load
//   reg_write, reg_dst, mem_to_reg  register-file controls
//   illegal           one-cycle pulse in DECODE on an unassigned opcode
//   halted            high while in HALT
//   state             current state encoding
module main_control_fsm
    import minimips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ALUop,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:                   state_d = ST_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_d = ST_EXEC_I;
                    OP_LW, OP_SW:               state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:             state_d = ST_BRANCH;
                    OP_J:                       state_d = ST_JUMP;
                    OP_HALT:                    state_d = ST_HALT;
                    default:                    state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R:   state_d = ST_WB_ALU;
            ST_EXEC_I:   state_d = ST_WB_ALU;
            ST_WB_ALU:   state_d = ST_FETCH;
            // Only lw and sw reach MEM_ADDR, so anything but lw is a store
            ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end
            end
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_FETCH;
        endcase
    end

    assign state = state_q;

    ctrl_output_decode u_decode (
        .state_i         (state_q),
        .opcode_i        (opcode),
        .zero_i          (zero),
        .mem_ready_i     (mem_ready),
        .aluop_o         (ALUop),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .pc_src_o        (pc_src),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .iord_o          (iord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .reg_write_o     (reg_write),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .illegal_o       (illegal),
        .halted_o        (halted)
    );

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - table-driven self-checking bench for main_control_fsm
module tb_main_control_fsm;
    import minimips_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] ALUop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       halted;
    logic [3:0] state;

    main_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .ALUop         (ALUop),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .halted        (halted),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ALUop, src_a, src_b, pc_src, strobes}; strobes bit order:
    // pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    // reg_write, reg_dst, mem_to_reg, illegal, halted
    logic [18:0] act;
    assign act = {ALUop, alu_src_a, alu_src_b, pc_src,
                  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, illegal, halted};

    localparam logic [10:0] S_NONE  = 11'b000_0000_0000;
    localparam logic [10:0] S_FWAIT = 11'b000_1000_0000;
    localparam logic [10:0] S_FRDY  = 11'b100_1010_0000;
    localparam logic [10:0] S_ILL   = 11'b000_0000_0010;
    localparam logic [10:0] S_WBR   = 11'b000_0001_1000;
    localparam logic [10:0] S_WBI   = 11'b000_0001_0000;
    localparam logic [10:0] S_MRD   = 11'b001_1000_0000;
    localparam logic [10:0] S_MWB   = 11'b000_0001_0100;
    localparam logic [10:0] S_MWR   = 11'b001_0100_0000;
    localparam logic [10:0] S_BRT   = 11'b010_0000_0000;
    localparam logic [10:0] S_JMP   = 11'b100_0000_0000;
    localparam logic [10:0] S_HLT   = 11'b000_0000_0001;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        zero;
        logic        rdy;
        logic        chk;
        logic [3:0]  st;
        logic [18:0] ctl;
    } vec_t;

    vec_t vecs[$];
    int   passed;
    int   total;

    function automatic logic [18:0] ctl(input logic [2:0] aluop, input logic a,
                                        input logic [1:0] b, input logic [1:0] pcs,
                                        input logic [10:0] strb);
        return {aluop, a, b, pcs, strb};
    endfunction

    task automatic add(input logic r, input logic [3:0] op, input logic z,
                       input logic rdy, input logic c, input logic [3:0] st,
                       input logic [18:0] e);
        vec_t v;
        v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.chk = c; v.st = st; v.ctl = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance past the rising edge
    task automatic step(input string nm, input logic r, input logic [3:0] op,
                        input logic z, input logic rdy, input logic c,
                        input logic [3:0] est, input logic [18:0] ectl);
        rst = r; opcode = op; zero = z; mem_ready = rdy;
        @(negedge clk);
        if (c) begin
            total++;
            if (state !== est)
                $display("FAIL %s state: got %0d expected %0d", nm, state, est);
            else
                passed++;
            total++;
            if (act !== ectl)
                $display("FAIL %s outputs: got %b expected %b", nm, act, ectl);
            else
                passed++;
        end
        @(posedge clk);
        #1;
    endtask

    logic [18:0] c_fw, c_fr, c_dec, c_ill, c_exr, c_wbr, c_wbi, c_ma;
    logic [18:0] c_mrd, c_mwb, c_mwr, c_brt, c_brn, c_j, c_h;

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;

        c_fw  = ctl(3'b000, 1'b0, 2'b01, 2'b00, S_FWAIT);
        c_fr  = ctl(3'b000, 1'b0, 2'b01, 2'b00, S_FRDY);
        c_dec = ctl(3'b000, 1'b0, 2'b10, 2'b00, S_NONE);
        c_ill = ctl(3'b000, 1'b0, 2'b10, 2'b00, S_ILL);
        c_exr = ctl(3'b111, 1'b1, 2'b00, 2'b00, S_NONE);
        c_wbr = ctl(3'b000, 1'b0, 2'b00, 2'b00, S_WBR);
        c_wbi = ctl(3'b000, 1'b0, 2'b00, 2'b00, S_WBI);
        c_ma  = ctl(3'b000, 1'b1, 2'b10, 2'b00, S_NONE);
        c_mrd = ctl(3'b000, 1'b0, 2'b00, 2'b00, S_MRD);
        c_mwb = ctl(3'b000, 1'b0, 2'b00, 2'b00, S_MWB);
        c_mwr = ctl(3'b000, 1'b0, 2'b00, 2'b00, S_MWR);
        c_brt = ctl(3'b001, 1'b1, 2'b00, 2'b01, S_BRT);
        c_brn = ctl(3'b001, 1'b1, 2'b00, 2'b01, S_NONE);
        c_j   = ctl(3'b000, 1'b0, 2'b00, 2'b10, S_JMP);
        c_h   = ctl(3'b000, 1'b0, 2'b00, 2'b00, S_HLT);

        // Reset for two cycles, then FETCH waiting on memory
        add(1, OP_RTYPE, 0, 0, 0, ST_FETCH, c_fw);
        add(1, OP_RTYPE, 0, 0, 0, ST_FETCH, c_fw);
        add(0, OP_RTYPE, 0, 0, 1, ST_FETCH, c_fw);
        // R-type, 4 cycles
        add(0, OP_RTYPE, 0, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_RTYPE, 0, 1, 1, ST_DECODE, c_dec);
        add(0, OP_RTYPE, 0, 1, 1, ST_EXEC_R, c_exr);
        add(0, OP_RTYPE, 0, 1, 1, ST_WB_ALU, c_wbr);
        // addi / andi / ori
        add(0, OP_ADDI, 0, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_ADDI, 0, 1, 1, ST_DECODE, c_dec);
        add(0, OP_ADDI, 0, 1, 1, ST_EXEC_I, ctl(3'b000, 1'b1, 2'b10, 2'b00, S_NONE));
        add(0, OP_ADDI, 0, 1, 1, ST_WB_ALU, c_wbi);
        add(0, OP_ANDI, 0, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_ANDI, 0, 1, 1, ST_DECODE, c_dec);
        add(0, OP_ANDI, 0, 1, 1, ST_EXEC_I, ctl(3'b010, 1'b1, 2'b10, 2'b00, S_NONE));
        add(0, OP_ANDI, 0, 1, 1, ST_WB_ALU, c_wbi);
        add(0, OP_ORI,  0, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_ORI,  0, 1, 1, ST_DECODE, c_dec);
        add(0, OP_ORI,  0, 1, 1, ST_EXEC_I, ctl(3'b011, 1'b1, 2'b10, 2'b00, S_NONE));
        add(0, OP_ORI,  0, 1, 1, ST_WB_ALU, c_wbi);
        // lw with two wait states in MEM_RD, 7 cycles
        add(0, OP_LW, 0, 1, 1, ST_FETCH,    c_fr);
        add(0, OP_LW, 0, 1, 1, ST_DECODE,   c_dec);
        add(0, OP_LW, 0, 1, 1, ST_MEM_ADDR, c_ma);
        add(0, OP_LW, 0, 0, 1, ST_MEM_RD,   c_mrd);
        add(0, OP_LW, 0, 0, 1, ST_MEM_RD,   c_mrd);
        add(0, OP_LW, 0, 1, 1, ST_MEM_RD,   c_mrd);
        add(0, OP_LW, 0, 1, 1, ST_MEM_WB,   c_mwb);
        // sw, 4 cycles
        add(0, OP_SW, 0, 1, 1, ST_FETCH,    c_fr);
        add(0, OP_SW, 0, 1, 1, ST_DECODE,   c_dec);
        add(0, OP_SW, 0, 1, 1, ST_MEM_ADDR, c_ma);
        add(0, OP_SW, 0, 1, 1, ST_MEM_WR,   c_mwr);
        // beq zero=1 taken, bne zero=1 not taken, bne zero=0 taken
        add(0, OP_BEQ, 1, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_BEQ, 1, 1, 1, ST_DECODE, c_dec);
        add(0, OP_BEQ, 1, 1, 1, ST_BRANCH, c_brt);
        add(0, OP_BNE, 1, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_BNE, 1, 1, 1, ST_DECODE, c_dec);
        add(0, OP_BNE, 1, 1, 1, ST_BRANCH, c_brn);
        add(0, OP_BNE, 0, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_BNE, 0, 1, 1, ST_DECODE, c_dec);
        add(0, OP_BNE, 0, 1, 1, ST_BRANCH, c_brt);
        // j
        add(0, OP_J, 0, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_J, 0, 1, 1, ST_DECODE, c_dec);
        add(0, OP_J, 0, 1, 1, ST_JUMP,   c_j);
        // illegal 1010, then halt held for 10 cycles whatever mem_ready does
        add(0, 4'b1010, 0, 1, 1, ST_FETCH,  c_fr);
        add(0, 4'b1010, 0, 1, 1, ST_DECODE, c_ill);
        add(0, OP_HALT, 0, 0, 1, ST_FETCH,  c_fw);
        add(0, OP_HALT, 0, 1, 1, ST_FETCH,  c_fr);
        add(0, OP_HALT, 0, 1, 1, ST_DECODE, c_dec);
        for (int k = 0; k < 10; k++) begin
            add(0, OP_HALT, 0, k[0], 1, ST_HALT, c_h);
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].zero,
                 vecs[i].rdy, vecs[i].chk, vecs[i].st, vecs[i].ctl);
        end

        // Only reset leaves HALT
        step("halt_rst",  1, OP_HALT, 0, 1, 1, ST_HALT,  c_h);
        step("halt_exit", 0, OP_SW,   0, 0, 1, ST_FETCH, c_fw);

        // Reset asserted while a store waits in MEM_WR
        step("sw_fetch",   0, OP_SW, 0, 1, 1, ST_FETCH,    c_fr);
        step("sw_decode",  0, OP_SW, 0, 1, 1, ST_DECODE,   c_dec);
        step("sw_addr",    0, OP_SW, 0, 1, 1, ST_MEM_ADDR, c_ma);
        step("sw_wait",    0, OP_SW, 0, 0, 1, ST_MEM_WR,   c_mwr);
        step("sw_rst",     1, OP_SW, 0, 0, 1, ST_MEM_WR,   c_mwr);
        step("sw_abandon", 0, OP_SW, 0, 0, 1, ST_FETCH,    c_fw);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle main control unit for the MiniMIPS processor. Decodes the 4-bit instruction opcode, sequences each instruction through fetch/decode/execute/memory/writeback states, and drives the datapath strobes and the 3-bit ALUop code that the ALU control stage consumes together with the function field. It waits on a memory ready handshake and stops in a halt state on the HALT opcode.

## Interface
Parameters:
- none; all encodings are fixed constants in the shared package.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk
- opcode  in  4  instruction register opcode field; valid from DECODE onward
- zero  in  1  ALU zero flag; sampled in BRANCH
- mem_ready  in  1  memory completes the current read or write this cycle
- ALUop  out  3  000 add, 001 sub, 010 and, 011 or, 111 func-decoded (R-type)
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 1, 10 = sign-extended immediate
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified inside this block by zero / ~zero
- iord  out  1  memory address from 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1  memory strobes, held until mem_ready
- ir_write  out  1  instruction register load
- reg_write, reg_dst, mem_to_reg  out  1  register-file controls (reg_dst 1 = rd)
- illegal  out  1  one-cycle pulse in DECODE on an unassigned opcode
- halted  out  1  high while in HALT
- state  out  4  current state encoding, for debug

## Operation
- Opcodes: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 lw, 0101 sw, 0110 beq, 0111 bne, 1000 j, 1111 halt; all others illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
- FETCH: mem_read, iord=0, ir_write, alu_src_a=0, alu_src_b=01, ALUop=000, pc_src=00. pc_write and ir_write are asserted only in the cycle mem_ready=1. Stays in FETCH until then, then goes to DECODE.
- DECODE: ALUop=000, alu_src_a=0, alu_src_b=10 (branch target into ALUOut). Next state by opcode:
  - R-type → EXEC_R
  - addi/andi/ori → EXEC_I
  - lw/sw → MEM_ADDR
  - beq/bne → BRANCH
  - j → JUMP
  - halt → HALT
  - illegal → FETCH, with the illegal pulse
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUop=111 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, ALUop=000/010/011 for addi/andi/ori → WB_ALU.
- WB_ALU: reg_write; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUop=000 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read, iord=1; waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write, iord=1; waits for mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUop=001, pc_src=01. PC loads when (beq & zero) | (bne & ~zero) → FETCH.
- JUMP: pc_write, pc_src=10 → FETCH.
- HALT: absorbing state; only rst leaves it.
- Every output not listed for a state is 0. ALUop defaults to 000.

## Timing
- Moore outputs decoded from the state register, except the FETCH PC/IR strobes and the branch PC load, which are qualified combinationally.
- Reset: on the rising edge with rst=1, state=FETCH. rst mid-instruction abandons it: no further strobes; the next cycle is FETCH with mem_read=1 and all other strobes 0.
- Cycle counts with zero wait states, counting FETCH as 1 cycle: R/imm 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Each wait state adds 1 cycle in FETCH, MEM_RD or MEM_WR. While waiting, the strobes stay constant.
- mem_ready outside a memory state is ignored.

## Structure
- Package minimips_ctrl_pkg holds:
  - the opcode constants
  - the ALUop codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_FUNC)
  - the 4-bit state encodings, shared with the ALU control stage and the testbench
- One sub-module, ctrl_output_decode: purely combinational decode of state, opcode, zero and mem_ready to the output strobes.
- The top module holds the state register and the next-state logic.

## Test plan
- rst=1 for 2 cycles, then release → state=FETCH, mem_read=1, all other strobes 0, halted=0.
- R-type, mem_ready always 1 → 4-cycle sequence; ALUop=111 in EXEC_R; reg_write=1 and reg_dst=1 in cycle 4.
- lw with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; mem_read and iord held; mem_to_reg=1 in MEM_WB.
- beq with zero=1, then bne with zero=1 → PC loads only for beq; ALUop=001 in both.
- Opcode 1010 → illegal pulses for 1 cycle in DECODE, then FETCH; next, opcode 1111 → halted=1 held for 10 cycles regardless of mem_ready.
- rst asserted during MEM_WR → mem_write drops on the next edge, state=FETCH.
